// File: rtl/serial_adder_seq.sv
// serial_adder_seq: bit-serial adder, one full-adder step per clock,
// LSB first, with valid/ready handshakes on operand and result sides.
module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             sbit;
  logic             nc;

  // Full-adder step on the current operand LSBs and the carry flop.
  always_comb begin
    sbit = a_sr[0] ^ b_sr[0] ^ carry;
    nc   = (a_sr[0] & b_sr[0]) |
           (a_sr[0] & carry) |
           (b_sr[0] & carry);
  end

  // Control FSM, serial datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr     <= op_a;
            b_sr     <= op_b;
            carry    <= cin;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          a_sr     <= a_sr >> 1;
          b_sr     <= b_sr >> 1;
          sum[cnt] <= sbit;
          carry    <= nc;
          if (cnt == LAST) begin
            // carry holds the carry into the MSB here
            cout      <= nc;
            ovf       <= carry ^ nc;
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_seq.sv
// tb_serial_adder_seq: directed literal cases plus randomized
// traffic checked against a transaction-level reference model.
module tb_serial_adder_seq;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  serial_adder_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: an accepted set yields a+b+cin after W edges
  // and is held until taken; idle shows the last result.
  bit           mon_en = 0;
  bit           have   = 0;
  int           left   = 0;
  logic [W-1:0] exp_s  = '0;
  logic         exp_co = 1'b0;
  logic         exp_ov = 1'b0;
  logic [W-1:0] shw_s  = '0;
  logic         shw_co = 1'b0;
  logic         shw_ov = 1'b0;
  logic [W:0]   tot;
  int           n_acc   = 0;
  int           n_done  = 0;
  int           n_abort = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready", in_ready, !have);
      chk("busy", busy, have && left > 0);
      chk("out_valid", out_valid, have && left == 0);
      if (have && left == 0) begin
        chk("done_sum", sum, exp_s);
        chk("done_cout", cout, exp_co);
        chk("done_ovf", ovf, exp_ov);
      end else if (!have) begin
        chk("idle_sum", sum, shw_s);
        chk("idle_cout", cout, shw_co);
        chk("idle_ovf", ovf, shw_ov);
      end
      if (rst) begin
        if (have) n_abort++;
        have   = 0;
        shw_s  = '0;
        shw_co = 1'b0;
        shw_ov = 1'b0;
      end else if (!have) begin
        if (in_valid) begin
          tot = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, cin};
          exp_s  = tot[W-1:0];
          exp_co = tot[W];
          exp_ov = (op_a[W-1] == op_b[W-1]) &&
                   (tot[W-1] != op_a[W-1]);
          have = 1;
          left = W;
          n_acc++;
        end
      end else if (left > 0) begin
        left--;
      end else if (out_ready) begin
        have   = 0;
        shw_s  = exp_s;
        shw_co = exp_co;
        shw_ov = exp_ov;
        n_done++;
      end
    end
  end

  function automatic logic [W-1:0] pick();
    int r;
    r = $urandom_range(0, 5);
    if (r == 0) return '0;
    if (r == 1) return '1;
    return W'($urandom);
  endfunction

  // One directed operation with literal expectations.
  task automatic run_op(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic c,
                        input logic [W-1:0] es,
                        input logic eco,
                        input logic eov,
                        input int hold,
                        input int noise);
    int n;
    @(posedge clk); #1;
    op_a = a; op_b = b; cin = c;
    in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", n < 50, 1);
    @(posedge clk); #1;
    in_valid = (noise > 0);
    op_a = 8'h11;
    op_b = 8'h22;
    cin  = 1'b1;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk); #1;
      n++;
      if (n >= noise) in_valid = 1'b0;
    end
    chk("latency", n, W);
    chk("lit_sum", sum, es);
    chk("lit_cout", cout, eco);
    chk("lit_ovf", ovf, eov);
    repeat (hold) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", {cout, ovf, sum}, {eco, eov, es});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_in_ready", in_ready, 1);
    chk("post_out_valid", out_valid, 0);
    chk("post_sum", sum, es);
  endtask

  initial begin
    int cyc;
    int start;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);

    run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, 0);
    run_op(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1, 5, 0);
    run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 0, 3);
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1, 0);
    run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0);

    // abort a run after bit 3 with a one-cycle reset
    @(posedge clk); #1;
    op_a = 8'hAA; op_b = 8'h55; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("abort_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum, 0);
    run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 0, 0);

    // randomized traffic with backpressure
    start = n_acc;
    cyc = 0;
    while (n_acc - start < 1000 && cyc < 60000) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      op_a      = pick();
      op_b      = pick();
      cin       = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      cyc++;
    end
    chk("random_budget", cyc < 60000, 1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (W + 6) @(posedge clk);
    #1;
    chk("handshake_count", n_acc, n_done + n_abort);
    chk("abort_count", n_abort, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
